lfsr_stream_cipher: RTL
=======================

LFSR_STREAM_CIPHER -- requirements
Module: lfsr_stream_cipher

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: LFSR state width in bits, legal range 4 to 64.
REQ-002 The block SHALL have parameter TAPS, default 16'hB400: feedback mask, WIDTH bits wide; bit k set means state bit k feeds the XOR.
REQ-003 The block SHALL have parameter SEED, default 16'hACE1: reset and fallback state, WIDTH bits wide, nonzero.
REQ-004 The block SHALL have parameter DW, default 8: data bits per beat, legal range 1 to WIDTH.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, all flops on its rising edge.
REQ-006 The block SHALL have port clr, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port seed_load, input, 1 bit: load seed_in into the LFSR this cycle.
REQ-008 The block SHALL have port seed_in, input, WIDTH bits: new LFSR state.
REQ-009 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-011 The block SHALL have port in_data, input, DW bits: plaintext or ciphertext beat.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the sink accepts a beat.
REQ-014 The block SHALL have port out_data, output, DW bits: in_data XOR key.
REQ-015 The block SHALL have port beat_cnt, output, 32 bits: number of beats accepted since the last reset or seed load.

Function
REQ-016 One LFSR step SHALL be defined as: key bit = state[WIDTH-1]; fb = XOR-reduce(state & TAPS); next state = {state[WIDTH-2:0], fb}.
REQ-017 The key for a beat SHALL be DW consecutive key bits, with the first bit mapped to key[DW-1] and the last to key[0].
REQ-018 The LFSR SHALL advance exactly DW steps in the cycle a beat is accepted, and SHALL hold its state otherwise.
REQ-019 A beat SHALL be accepted when in_valid and in_ready are both high on a rising clk edge.
REQ-020 in_ready SHALL equal (!out_valid || out_ready) && !seed_load.
REQ-021 On accept, out_data SHALL be registered as in_data ^ key and out_valid SHALL be set, giving a latency of 1 cycle.
REQ-022 out_valid SHALL clear on an out_ready handshake when no new beat is accepted in the same cycle.
REQ-023 Simultaneous output handshake and input accept SHALL replace out_data with no bubble, sustaining 1 beat per cycle.
REQ-024 While out_valid is high and out_ready is low, out_data and out_valid SHALL remain stable.
REQ-025 A seed_load SHALL set state to seed_in, or to SEED if seed_in == 0 (lock-up guard), and SHALL clear beat_cnt.
REQ-026 A seed_load SHALL take priority over accept: no beat is accepted in that cycle.
REQ-027 A seed_load SHALL leave a pending out_data/out_valid untouched.
REQ-028 beat_cnt SHALL increment by 1 per accepted beat and SHALL wrap from 2^32-1 to 0.
REQ-029 The LFSR state SHALL never become 0 through normal stepping.

Reset
REQ-030 On clr low, asynchronously: state = SEED, out_valid = 0, out_data = 0, beat_cnt = 0.
REQ-031 in_ready SHALL be 1 during and after reset, provided seed_load is low.
REQ-032 A reset mid-stream SHALL drop any pending output beat.
REQ-033 After release of clr, the first accepted beat SHALL use the key derived from SEED.

Verification
REQ-034 Defaults, after reset, beats 8'h00 then 8'h00 with out_ready=1 -> out_data 8'hAC then 8'hE1; beat_cnt=2.
REQ-035 Defaults, after reset, beat 8'hFF -> out_data 8'h53 one cycle later.
REQ-036 seed_load with seed_in=16'h1234, then beats 8'h00, 8'h00 -> out_data 8'h12, 8'h34; beat_cnt cleared before the first beat.
REQ-037 seed_load with seed_in=0, then beat 8'h00 -> out_data 8'hAC (SEED fallback).
REQ-038 out_ready=0 with continuous in_valid -> one beat accepted, in_ready=0 after it, out_data stable for 10 cycles; on out_ready=1, streaming resumes at 1 beat/cycle with no beat lost or duplicated.
REQ-039 Round-trip: 1000 random bytes encrypted, then reset, then the ciphertext fed back -> output equals the original bytes; repeat with DW=1 and WIDTH=32.

Source files
------------

// File: rtl/lfsr_stream_cipher.sv
// Stream cipher: in_data is XORed with DW keystream bits from a Fibonacci LFSR,
// with a one-deep registered output stage and valid/ready handshakes on both sides.
module lfsr_stream_cipher #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter int               DW    = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [31:0]      beat_cnt
);

    // One shift: MSB leaves as the key bit, the tap parity enters at bit 0.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    logic [WIDTH-1:0] state_q, state_d, adv_s;
    logic [DW-1:0]    out_data_q, out_data_d, key_s;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      beat_cnt_q, beat_cnt_d;
    logic             in_ready_s, accept_s;

    // Handshake decode and keystream for the current beat.
    always_comb begin
        in_ready_s = (!out_valid_q || out_ready) && !seed_load;
        accept_s   = in_valid && in_ready_s;
        // The DW key bits are exactly the top DW bits of the current state.
        key_s      = state_q[WIDTH-1 -: DW];
        adv_s      = state_q;
        for (int i = 0; i < DW; i++) begin
            adv_s = lfsr_step(adv_s);
        end
    end

    // Next-state for LFSR, beat counter and output stage.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (seed_load) begin
            state_d    = (seed_in == '0) ? SEED : seed_in;
            beat_cnt_d = 32'd0;
        end else if (accept_s) begin
            // Guard against lock-up should a non-primitive TAPS ever reach zero.
            state_d    = (adv_s == '0) ? SEED : adv_s;
            beat_cnt_d = beat_cnt_q + 32'd1;
        end else begin
            state_d    = state_q;
        end
        if (accept_s) begin
            out_data_d  = in_data ^ key_s;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= SEED;
            beat_cnt_q  <= 32'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign beat_cnt  = beat_cnt_q;

endmodule
